// File: rtl/dsp48a1_pkg.sv
// Shared OPMODE encodings and sequencer state type for the DSP48A1 MAC controller.
package dsp48a1_pkg;

  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P    = 2'b10;

  localparam logic [7:0] OPM_FIRST = {4'b0000, Z_ZERO, X_M};
  localparam logic [7:0] OPM_ACC   = {4'b0000, Z_P, X_M};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dsp_opmode_pipe.sv
// CE-gated OPMODE delay line; keeps each operand's code aligned with its product in the slice.
module dsp_opmode_pipe #(
  parameter int OPM_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] stage [OPM_DLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OPM_DLY; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= d;
      for (int unsigned i = 1; i < OPM_DLY; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[OPM_DLY-1];

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Sequences one DSP48A1 slice through a signed dot product and returns the 48-bit accumulation.
module dsp48a1_mac_ctrl
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int LAT     = 3,
  parameter int OPM_DLY = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_cout,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  input  logic [47:0]      dsp_P,
  input  logic             dsp_CARRYOUT
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    drain_cnt;
  logic             first;
  logic             drain_last;
  logic [7:0]       opm_in;

  assign dsp_A      = op_a;
  assign dsp_B      = op_b;
  assign drain_last = (drain_cnt == DW'(LAT - 1));

  // DRAIN spends LAT-1 CE cycles flushing the slice, then one idle cycle whose edge samples P.
  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    dsp_CE    = 1'b0;
    opm_in    = '0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_nxt = (job_len == '0) ? HOLD : LOAD;
      end
      LOAD: begin
        op_ready = 1'b1;
        dsp_CE   = op_valid;
        opm_in   = first ? OPM_FIRST : OPM_ACC;
        if (op_valid && remaining == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        dsp_CE = !drain_last;
        if (drain_last) state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      drain_cnt <= '0;
      res_data  <= '0;
      res_cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (job_valid) begin
          remaining <= job_len;
          first     <= 1'b1;
          res_data  <= '0;
          res_cout  <= 1'b0;
        end
        LOAD: if (op_valid) begin
          remaining <= remaining - LEN_W'(1);
          first     <= 1'b0;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_last) begin
            res_data <= dsp_P;
            res_cout <= dsp_CARRYOUT;
          end
        end
        default: ;
      endcase
    end
  end

  dsp_opmode_pipe #(.OPM_DLY(OPM_DLY)) u_opm_pipe (
    .clk (CLK),
    .rst (RST),
    .ce  (dsp_CE),
    .d   (opm_in),
    .q   (dsp_OPMODE)
  );

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Randomized self-checking bench: drives jobs into the controller with a behavioural DSP48A1 slice attached.
module tb_dsp48a1_mac_ctrl;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        job_valid, job_ready;
  logic [7:0]  job_len;
  logic        op_valid, op_ready;
  logic [17:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [47:0] res_data;
  logic        res_cout;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CE;
  logic [47:0] dsp_P;
  logic        dsp_CARRYOUT;

  int checks = 0;
  int failures = 0;

  logic [17:0] qa[$];
  logic [17:0] qb[$];
  int          qbub[$];

  always #5 CLK = ~CLK;

  dsp48a1_mac_ctrl #(.LEN_W(8), .LAT(LAT), .OPM_DLY(1)) dut (
    .CLK(CLK), .RST(RST),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE),
    .dsp_P(dsp_P), .dsp_CARRYOUT(dsp_CARRYOUT)
  );

  // Slice model: A1/B1 -> M -> P, OPMODE register, all on one CE. Never reset, starts dirty.
  logic signed [17:0] s_a1 = 18'sd1234;
  logic signed [17:0] s_b1 = -18'sd77;
  logic signed [35:0] s_m  = 36'sd98765;
  logic [47:0]        s_p  = 48'hDEAD_BEEF_0123;
  logic               s_co = 1'b1;
  logic [7:0]         s_opm = 8'h09;
  logic [48:0]        s_sum;

  always @(posedge CLK) begin
    if (dsp_CE) begin
      s_sum = ((s_opm[3:2] == 2'b10) ? {s_p[47], s_p} : 49'd0)
            + ((s_opm[1:0] == 2'b01) ? {{13{s_m[35]}}, s_m} : 49'd0);
      s_p   <= s_sum[47:0];
      s_co  <= s_sum[48];
      s_m   <= s_a1 * s_b1;
      s_a1  <= $signed(dsp_A);
      s_b1  <= $signed(dsp_B);
      s_opm <= dsp_OPMODE;
    end
  end
  assign dsp_P        = s_p;
  assign dsp_CARRYOUT = s_co;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dot product of the queued pairs, wrapping at 48 bits; carry is bit 48 of the final signed add.
  function automatic void ref_job(output logic [47:0] s, output logic c);
    logic [48:0] t;
    longint      pr;
    s = '0;
    c = 1'b0;
    foreach (qa[k]) begin
      pr = longint'($signed(qa[k])) * longint'($signed(qb[k]));
      t  = {s[47], s} + 49'(pr);
      s  = t[47:0];
      c  = t[48];
    end
  endfunction

  task automatic push_op(input int a, input int b, input int bub);
    qa.push_back(18'(a));
    qb.push_back(18'(b));
    qbub.push_back(bub);
  endtask

  task automatic clear_ops();
    qa.delete();
    qb.delete();
    qbub.delete();
  endtask

  task automatic do_job(input int rdy_wait);
    logic [47:0] exp_sum;
    logic        exp_cout;
    int          len, cyc, ces;
    len = qa.size();
    ref_job(exp_sum, exp_cout);
    job_valid = 1'b1;
    job_len   = 8'(len);
    #1;
    check("job_ready_idle", job_ready, 1);
    @(posedge CLK); #1;
    job_valid = 1'b0;
    job_len   = 8'($urandom);
    check("accepted", (len == 0) ? res_valid : op_ready, 1);
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < qbub[k]; j++) begin
        op_valid = 1'b0;
        op_a = 18'($urandom);
        op_b = 18'($urandom);
        #1;
        check("bubble_ce", dsp_CE, 0);
        check("bubble_op_ready", op_ready, 1);
        @(posedge CLK); #1;
      end
      op_valid = 1'b1;
      op_a = qa[k];
      op_b = qb[k];
      #1;
      check("load_ce", dsp_CE, 1);
      @(posedge CLK); #1;
      check("opmode", dsp_OPMODE, (k == 0) ? 8'h01 : 8'h09);
    end
    op_valid = 1'b0;
    cyc = 0;
    ces = 0;
    while (!res_valid && cyc < 20) begin
      ces += int'(dsp_CE);
      @(posedge CLK); #1;
      cyc++;
    end
    check("result_latency", cyc, (len == 0) ? 0 : LAT);
    check("drain_ce_cycles", ces, (len == 0) ? 0 : LAT - 1);
    check("res_data", res_data, exp_sum);
    check("res_cout", res_cout, exp_cout);
    res_ready = 1'b0;
    for (int w = 0; w < rdy_wait; w++) begin
      job_valid = 1'b1;
      job_len   = 8'($urandom_range(1, 255));
      op_valid  = 1'($urandom);
      #1;
      check("hold_job_ready", job_ready, 0);
      check("hold_op_ready", op_ready, 0);
      check("hold_ce", dsp_CE, 0);
      @(posedge CLK); #1;
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp_sum);
    end
    op_valid  = 1'b0;
    job_valid = (rdy_wait > 0);
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    job_valid = 1'b0;
    check("post_hs_valid", res_valid, 0);
    check("post_hs_idle", job_ready, 1);
  endtask

  initial begin
    RST = 1'b1;
    job_valid = 1'($urandom); job_len = 8'($urandom);
    op_valid = 1'($urandom); op_a = 18'($urandom); op_b = 18'($urandom);
    res_ready = 1'($urandom);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_job_ready", job_ready, 1);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ce", dsp_CE, 0);
    check("rst_opmode", dsp_OPMODE, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_cout", res_cout, 0);
    job_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;

    clear_ops();
    push_op(2, 3, 0); push_op(4, 5, 0); push_op(-1, 7, 0);
    do_job(0);

    clear_ops();
    push_op(20, 10, 0); push_op(5, 6, 2);
    do_job(0);

    clear_ops();
    do_job(0);

    clear_ops();
    push_op(-300, 1000, 0); push_op(17, -3, 1);
    do_job(5);
    clear_ops();
    push_op(9, 9, 0);
    do_job(0);

    // Abort a job after one operand, then confirm the next job is clean.
    job_valid = 1'b1; job_len = 8'd3;
    @(posedge CLK); #1;
    job_valid = 1'b0;
    op_valid = 1'b1; op_a = 18'(131071); op_b = 18'(131071);
    @(posedge CLK); #1;
    op_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("midrst_job_ready", job_ready, 1);
    check("midrst_op_ready", op_ready, 0);
    check("midrst_ce", dsp_CE, 0);
    check("midrst_opmode", dsp_OPMODE, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_ops();
    push_op(3, 4, 0);
    do_job(0);

    for (int n = 0; n < 30; n++) begin
      int len;
      clear_ops();
      len = $urandom_range(0, 6);
      for (int k = 0; k < len; k++)
        push_op(int'($signed(18'($urandom))), int'($signed(18'($urandom))), $urandom_range(0, 2));
      do_job($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp48a1_mac_ctrl.md
# dsp48a1_mac_ctrl

Sequencer that drives one DSP48A1 slice (`Spartan_6`) as a signed multiply-accumulate engine. It accepts a dot-product job of length N over a valid/ready handshake, then streams N 18x18 operand pairs into the slice. It gates the slice's clock enables and issues the matching OPMODE per operand, waits out the slice pipeline, and returns the 48-bit accumulated P over a valid/ready result port.

## Interface
- `LEN_W`, 8: width of job length.
- `LAT`, 3: number of CE-enabled edges from an operand-capture edge (inclusive) to P holding that product's contribution. This assumes the A1/B1, M and P registers are in use.
- `OPM_DLY`, 1: CE-enabled edges between an operand's issue and its OPMODE appearing on `dsp_OPMODE`.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `job_valid` in 1 / `job_ready` out 1 / `job_len` in LEN_W: job request; length 0 is legal.
- `op_valid` in 1 / `op_ready` out 1 / `op_a` in 18 / `op_b` in 18: signed operand stream.
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out 48 / `res_cout` out 1: result.
- `dsp_A` out 18, `dsp_B` out 18: wired to `op_a`, `op_b`.
- `dsp_OPMODE` out 8: to slice OPMODE.
- `dsp_CE` out 1: drives CEA, CEB, CEM, CEP and CEOPMODE together.
- `dsp_P` in 48, `dsp_CARRYOUT` in 1: from the slice.

## Operation
- States:
  - IDLE: `job_ready`=1.
  - LOAD: `op_ready`=1.
  - DRAIN.
  - HOLD: `res_valid`=1.
- IDLE transitions on `job_valid`:
  - `job_len`≠0: go to LOAD, with `remaining` set to `job_len` and `first` set to 1.
  - `job_len`=0: go to HOLD with `res_data`=0 and `res_cout`=0.
- LOAD:
  - `dsp_CE` = `op_valid`.
  - Each accepted operand decrements `remaining`.
  - The last accepted operand moves the state to DRAIN.
  - `op_valid`=0 (a bubble) freezes the whole slice; in-flight products stall with it.
- DRAIN:
  - `dsp_CE`=1 for exactly LAT-1 cycles.
  - It then moves to HOLD.
  - The transition edge registers `res_data`←`dsp_P` and `res_cout`←`dsp_CARRYOUT`.
- HOLD:
  - `dsp_CE`=0.
  - Outputs are stable.
  - `res_valid`&&`res_ready` returns the state to IDLE.
- OPMODE per operand:
  - OPM_FIRST = 8'b0000_0001 for the first operand of a job (X=M, Z=0, pre-adder bypassed, CIN=0). No P clear is needed.
  - OPM_ACC = 8'b0000_1001 for every later operand (X=M, Z=P).
  - The code travels an OPM_DLY-deep shift register that advances only when `dsp_CE`=1.
- Arithmetic:
  - Signed 18x18 products are sign-extended to 48 bits.
  - The sum wraps modulo 2^48.
  - `res_cout` is the slice CARRYOUT at capture.
- Outputs in IDLE and HOLD: `dsp_CE`=0, `op_ready`=0.
- `job_valid` outside IDLE is ignored. `res_ready` outside HOLD is ignored.
- `op_valid` outside LOAD is ignored. No operand is consumed.

## Timing
- Reset values:
  - State: IDLE.
  - `job_ready`=1.
  - `op_ready`=0, `res_valid`=0, `res_data`=0, `res_cout`=0.
  - `dsp_CE`=0.
  - `dsp_OPMODE`=0, and every stage of the OPMODE pipe is 0.
- Let tL be the edge capturing the last operand. `res_valid` rises at edge tL+LAT-1+1 = tL+LAT when there are no stalls; DRAIN cycles are never stalled.
- For len 0, `res_valid` rises at the edge after acceptance.
- The earliest next job is accepted one cycle after the result handshake.
- A bubble of k cycles delays the result by exactly k cycles.
- RST mid-job:
  - The block returns to IDLE immediately.
  - Slice registers are untouched.
  - A zeroed OPMODE pipe forces X=Z=0, so stale M values cannot pollute the next job.
  - The next job's OPM_FIRST overwrites P.

## Structure
- Package `dsp48a1_pkg`:
  - OPM_FIRST and OPM_ACC.
  - The OPMODE field constants (X_M, Z_P, Z_ZERO).
  - State enum {IDLE, LOAD, DRAIN, HOLD}.
- Sub-module `dsp_opmode_pipe`: CE-gated shift register, parameter OPM_DLY, 8 bits wide, reset to 0.
- Top level holds the FSM, the `remaining` and drain counters, and the result register.

## Test plan
- Reset:
  - Assert RST with random inputs.
  - Required: `job_ready`=1; `op_ready`, `res_valid`, `dsp_CE`, `dsp_OPMODE` and `res_data` all 0.
- Back-to-back job:
  - len=3 with pairs (2,3), (4,5), (-1,7).
  - Required: `res_data`=0x13 (19), `res_cout`=0, `res_valid` at tL+3.
  - Required: `dsp_OPMODE` sequence 0x01, 0x09, 0x09.
- Bubbles:
  - len=2 with pairs (20,10) and (5,6), and 2 idle cycles between them.
  - Required: `res_data`=0xE6 (230), `dsp_CE`=0 in both bubble cycles, result 2 cycles later than the no-bubble case.
- Zero length:
  - len=0.
  - Required: `res_valid`=1 at the edge after acceptance, `res_data`=0, `dsp_CE` never asserted.
- Backpressure:
  - Hold `res_ready` low for 5 cycles and drive `job_valid` high throughout.
  - Required: `res_data` stable, `job_ready`=0, no new job accepted.
  - Required: after the handshake, IDLE is reached and the new job is accepted the next cycle.
- Reset mid-job:
  - Assert RST after 1 of 3 operands, then run a new job with len=1 and pair (3,4).
  - Required: `res_data`=0x0C (12).
